// File: rtl/traffic_light_pkg.sv
// -----------------------------------------------------------------------------
// traffic_light_pkg
//   Shared definitions for the two-street traffic light controller:
//     - state_t      : controller state encoding (also visible on dbg_state)
//     - lamps_t      : packed lamp vector {Ga,Ya,Ra,Gb,Yb,Rb,Gw,Rw}
//     - L_*          : bit positions of each lamp inside lamps_t
//     - next_phase() : fixed phase rotation of the normal cycle
//     - decode_lamps(): lamp pattern for a state and the current flash level
//     - max2()       : helper for sizing the phase counter
// -----------------------------------------------------------------------------
package traffic_light_pkg;

   typedef enum logic [2:0] {
      ST_A_GREEN  = 3'd0,
      ST_A_YELLOW = 3'd1,
      ST_B_GREEN  = 3'd2,
      ST_B_YELLOW = 3'd3,
      ST_WALK     = 3'd4,
      ST_W_FLASH  = 3'd5,
      ST_ALL_RED  = 3'd6,
      ST_MAINT    = 3'd7
   } state_t;

   localparam int LAMP_W = 8;
   typedef logic [LAMP_W-1:0] lamps_t;

   // Lamp vector field positions, MSB first: Ga Ya Ra Gb Yb Rb Gw Rw
   localparam int L_GA = 7;
   localparam int L_YA = 6;
   localparam int L_RA = 5;
   localparam int L_GB = 4;
   localparam int L_YB = 3;
   localparam int L_RB = 2;
   localparam int L_GW = 1;
   localparam int L_RW = 0;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Normal cycle order; MAINT leaves through the all-red clearance.
   function automatic state_t next_phase(input state_t s);
      state_t n;
      case (s)
         ST_A_GREEN:  n = ST_A_YELLOW;
         ST_A_YELLOW: n = ST_B_GREEN;
         ST_B_GREEN:  n = ST_B_YELLOW;
         ST_B_YELLOW: n = ST_WALK;
         ST_WALK:     n = ST_W_FLASH;
         ST_W_FLASH:  n = ST_ALL_RED;
         ST_ALL_RED:  n = ST_A_GREEN;
         default:     n = ST_ALL_RED;
      endcase
      return n;
   endfunction

   function automatic lamps_t decode_lamps(input state_t s, input logic flash);
      lamps_t l;
      l = '0;
      case (s)
         ST_A_GREEN:  begin l[L_GA] = 1'b1; l[L_RB] = 1'b1; l[L_RW] = 1'b1; end
         ST_A_YELLOW: begin l[L_YA] = 1'b1; l[L_RB] = 1'b1; l[L_RW] = 1'b1; end
         ST_B_GREEN:  begin l[L_RA] = 1'b1; l[L_GB] = 1'b1; l[L_RW] = 1'b1; end
         ST_B_YELLOW: begin l[L_RA] = 1'b1; l[L_YB] = 1'b1; l[L_RW] = 1'b1; end
         ST_WALK:     begin l[L_RA] = 1'b1; l[L_RB] = 1'b1; l[L_GW] = 1'b1; end
         ST_W_FLASH:  begin l[L_RA] = 1'b1; l[L_RB] = 1'b1; l[L_RW] = flash; end
         ST_ALL_RED:  begin l[L_RA] = 1'b1; l[L_RB] = 1'b1; l[L_RW] = 1'b1; end
         ST_MAINT:    begin l[L_YA] = flash; l[L_YB] = flash; l[L_RW] = flash; end
         default:     l = '0;
      endcase
      return l;
   endfunction

   // Lamp pattern held while reset is asserted (A green, B red, walk red).
   localparam lamps_t RESET_LAMPS = decode_lamps(ST_A_GREEN, 1'b0);

endpackage

// File: rtl/tl_tick_gen.sv
// -----------------------------------------------------------------------------
// tl_tick_gen
//   Free-running clock divider. Counts 0..DIV-1 and asserts o_tick for the
//   single cycle in which the count equals DIV-1, then wraps to 0. With
//   DIV = 1 the tick is asserted every cycle.
// Ports:
//   i_clk   in  1  clock
//   i_rst   in  1  asynchronous active-high reset (count -> 0)
//   o_tick  out 1  one-cycle timing tick
// -----------------------------------------------------------------------------
module tl_tick_gen #(
   parameter int DIV = 1
)(
   input  logic i_clk,
   input  logic i_rst,
   output logic o_tick
);

   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (r_cnt == LAST) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/traffic_light_ctrl.sv
// -----------------------------------------------------------------------------
// traffic_light_ctrl
//   Tick-timed controller for a two-street intersection (A, B) with one
//   pedestrian walk signal. Cycle:
//     A green -> A yellow -> B green -> B yellow -> walk -> walk-red flash
//     -> all-red -> repeat
//   MAINT forces a flashing-caution maintenance mode; on release the
//   controller restarts through a full all-red clearance.
// Ports:
//   clk        in  1  clock
//   reset      in  1  asynchronous active-high reset
//   MAINT      in  1  maintenance request (synchronous, level)
//   Ga/Ya/Ra   out 1  street A lamps (registered)
//   Gb/Yb/Rb   out 1  street B lamps (registered)
//   Gw/Rw      out 1  walk green / walk red lamps (registered)
//   dbg_state  out 3  registered state encoding (only with TL_DEBUG_STATE_EN)
// Configuration macro:
//   TL_DEBUG_STATE_EN - when defined, adds the dbg_state output port.
// -----------------------------------------------------------------------------
module traffic_light_ctrl
   import traffic_light_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 50_000_000,
   parameter int TICK_HZ     = 1,
   parameter int A_GREEN_T   = 10,
   parameter int A_YELLOW_T  = 3,
   parameter int B_GREEN_T   = 10,
   parameter int B_YELLOW_T  = 3,
   parameter int W_GREEN_T   = 8,
   parameter int W_RFLASH_T  = 4,
   parameter int W_RSOLID_T  = 2
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       MAINT,
   output logic       Ga,
   output logic       Ya,
   output logic       Ra,
   output logic       Gb,
   output logic       Yb,
   output logic       Rb,
   output logic       Gw,
   output logic       Rw
`ifdef TL_DEBUG_STATE_EN
   ,
   output logic [2:0] dbg_state
`else
   // dbg_state port not present in this build
`endif
);

   localparam int DIV   = CLK_FREQ_HZ / TICK_HZ;
   localparam int MAX_T = max2(max2(max2(A_GREEN_T, A_YELLOW_T),
                                    max2(B_GREEN_T, B_YELLOW_T)),
                               max2(max2(W_GREEN_T, W_RFLASH_T), W_RSOLID_T));
   localparam int PC_W  = $clog2(MAX_T + 1);

   state_t            r_state;
   logic [PC_W-1:0]   r_pc;
   logic              r_flash;
   lamps_t            r_lamps;

   logic              w_tick;
   logic [PC_W-1:0]   w_phase_t;
   logic              w_last;
   state_t            w_next;

   tl_tick_gen #(
      .DIV (DIV)
   ) u_tick_gen (
      .i_clk  (clk),
      .i_rst  (reset),
      .o_tick (w_tick)
   );

   // Length of the current phase in ticks (MAINT never expires on its own).
   always_comb begin
      w_phase_t = PC_W'(1);
      case (r_state)
         ST_A_GREEN:  w_phase_t = PC_W'(A_GREEN_T);
         ST_A_YELLOW: w_phase_t = PC_W'(A_YELLOW_T);
         ST_B_GREEN:  w_phase_t = PC_W'(B_GREEN_T);
         ST_B_YELLOW: w_phase_t = PC_W'(B_YELLOW_T);
         ST_WALK:     w_phase_t = PC_W'(W_GREEN_T);
         ST_W_FLASH:  w_phase_t = PC_W'(W_RFLASH_T);
         ST_ALL_RED:  w_phase_t = PC_W'(W_RSOLID_T);
         default:     w_phase_t = PC_W'(1);
      endcase
   end

   assign w_last = (r_pc == (w_phase_t - PC_W'(1)));
   assign w_next = next_phase(r_state);

   // Lamps are decoded from the registered state/flash, so they follow the
   // state register by one clock.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_A_GREEN;
         r_pc    <= '0;
         r_flash <= 1'b0;
         r_lamps <= RESET_LAMPS;
      end else begin
         r_lamps <= decode_lamps(r_state, r_flash);
         if (MAINT) begin
            // Maintenance wins over any phase expiry in the same cycle.
            if (r_state != ST_MAINT) begin
               r_state <= ST_MAINT;
               r_pc    <= '0;
               r_flash <= 1'b1;
            end else if (w_tick) begin
               r_flash <= ~r_flash;
            end
         end else if (r_state == ST_MAINT) begin
            // Leave maintenance through a full all-red clearance.
            r_state <= ST_ALL_RED;
            r_pc    <= '0;
         end else if (w_tick) begin
            if (w_last) begin
               r_state <= w_next;
               r_pc    <= '0;
               if (w_next == ST_W_FLASH) begin
                  r_flash <= 1'b1;
               end
            end else begin
               r_pc <= r_pc + PC_W'(1);
               if (r_state == ST_W_FLASH) begin
                  r_flash <= ~r_flash;
               end
            end
         end
      end
   end

   assign Ga = r_lamps[L_GA];
   assign Ya = r_lamps[L_YA];
   assign Ra = r_lamps[L_RA];
   assign Gb = r_lamps[L_GB];
   assign Yb = r_lamps[L_YB];
   assign Rb = r_lamps[L_RB];
   assign Gw = r_lamps[L_GW];
   assign Rw = r_lamps[L_RW];

`ifdef TL_DEBUG_STATE_EN
   assign dbg_state = r_state;
`else
   // no debug state output in this build
`endif

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// -----------------------------------------------------------------------------
// tb_traffic_light_ctrl
//   Self-checking bench for traffic_light_ctrl at CLK 1 MHz, TICK 1 kHz
//   (DIV = 1000) with phase lengths 3,2,3,1,2,2,5 ticks. A schedule-based
//   reference model (phase index + ticks elapsed) predicts the lamp pattern
//   every cycle; safety invariants are checked on every cycle as well.
//   With TL_DEBUG_STATE_EN defined, dbg_state is also compared.
// -----------------------------------------------------------------------------
module tb_traffic_light_ctrl;

   localparam int DIV = 1000;
   localparam int NPH = 7;
   localparam int DUR [NPH] = '{3, 2, 3, 1, 2, 2, 5};

   // Expected lamp patterns {Ga,Ya,Ra,Gb,Yb,Rb,Gw,Rw}
   localparam logic [7:0] P_A_GREEN  = 8'b1000_0101;
   localparam logic [7:0] P_A_YELLOW = 8'b0100_0101;
   localparam logic [7:0] P_B_GREEN  = 8'b0011_0001;
   localparam logic [7:0] P_B_YELLOW = 8'b0010_1001;
   localparam logic [7:0] P_WALK     = 8'b0010_0110;
   localparam logic [7:0] P_ALL_RED  = 8'b0010_0101;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   logic maint = 1'b0;
   logic Ga, Ya, Ra, Gb, Yb, Rb, Gw, Rw;
`ifdef TL_DEBUG_STATE_EN
   logic [2:0] dbg_state;
`endif

   traffic_light_ctrl #(
      .CLK_FREQ_HZ (1_000_000),
      .TICK_HZ     (1000),
      .A_GREEN_T   (3),
      .A_YELLOW_T  (2),
      .B_GREEN_T   (3),
      .B_YELLOW_T  (1),
      .W_GREEN_T   (2),
      .W_RFLASH_T  (2),
      .W_RSOLID_T  (5)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .MAINT     (maint),
      .Ga        (Ga),
      .Ya        (Ya),
      .Ra        (Ra),
      .Gb        (Gb),
      .Yb        (Yb),
      .Rb        (Rb),
      .Gw        (Gw),
      .Rw        (Rw)
`ifdef TL_DEBUG_STATE_EN
      ,
      .dbg_state (dbg_state)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: position in the phase schedule
   int   m_cyc;       // clock edges since reset release
   int   m_phase;     // 0..6 index into the normal cycle
   int   m_ticks;     // ticks elapsed in the current phase
   int   m_mticks;    // ticks elapsed since entering maintenance
   bit   m_in_maint;
   logic [7:0] m_exp;
   bit   m_exp_maint;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
      end
   endtask

   function automatic logic [7:0] model_lamps();
      logic f;
      if (m_in_maint) begin
         f = ((m_mticks % 2) == 0);
         return {1'b0, f, 1'b0, 1'b0, f, 1'b0, 1'b0, f};
      end
      case (m_phase)
         0: return P_A_GREEN;
         1: return P_A_YELLOW;
         2: return P_B_GREEN;
         3: return P_B_YELLOW;
         4: return P_WALK;
         5: return {7'b0010_010, ((m_ticks % 2) == 0)};
         default: return P_ALL_RED;
      endcase
   endfunction

   function automatic void model_reset();
      m_cyc      = 0;
      m_phase    = 0;
      m_ticks    = 0;
      m_mticks   = 0;
      m_in_maint = 1'b0;
   endfunction

   // Advance the model by one clock edge with the given MAINT level.
   // Lamps seen after the edge reflect the state held before it.
   function automatic void model_step(input bit mt);
      bit tick;
      tick        = ((m_cyc % DIV) == DIV - 1);
      m_cyc       = m_cyc + 1;
      m_exp       = model_lamps();
      m_exp_maint = m_in_maint;
      if (mt) begin
         if (!m_in_maint) begin
            m_in_maint = 1'b1;
            m_mticks   = 0;
         end else if (tick) begin
            m_mticks = m_mticks + 1;
         end
      end else if (m_in_maint) begin
         m_in_maint = 1'b0;
         m_phase    = NPH - 1;
         m_ticks    = 0;
      end else if (tick) begin
         m_ticks = m_ticks + 1;
         if (m_ticks == DUR[m_phase]) begin
            m_phase = (m_phase + 1) % NPH;
            m_ticks = 0;
         end
      end
   endfunction

   task automatic step(input bit mt);
      logic [7:0] obs;
      maint = mt;
      @(posedge clk);
      model_step(mt);
      @(negedge clk);
      obs = {Ga, Ya, Ra, Gb, Yb, Rb, Gw, Rw};
      check("lamps", {24'd0, obs}, {24'd0, m_exp});
      check("no_ga_gb", {31'd0, Ga & Gb}, 32'd0);
      check("no_walk_conflict", {31'd0, Gw & (Ga | Gb)}, 32'd0);
      if (!m_exp_maint) begin
         check("one_per_street",
               {30'd0, ($countones({Ga, Ya, Ra}) == 1), ($countones({Gb, Yb, Rb}) == 1)},
               32'd3);
      end
`ifdef TL_DEBUG_STATE_EN
      check("dbg_state", {29'd0, dbg_state}, m_in_maint ? 32'd7 : m_phase);
`endif
   endtask

   // Reset is raised mid-cycle: the lamps must snap back without a clock edge.
   task automatic do_reset(input int cycles);
      @(negedge clk);
      #2;
      reset = 1'b1;
      maint = 1'b0;
      #1;
      check("reset_async", {24'd0, Ga, Ya, Ra, Gb, Yb, Rb, Gw, Rw}, {24'd0, P_A_GREEN});
      repeat (cycles) @(posedge clk);
      @(negedge clk);
      check("reset_hold", {24'd0, Ga, Ya, Ra, Gb, Yb, Rb, Gw, Rw}, {24'd0, P_A_GREEN});
      reset = 1'b0;
      model_reset();
      $display("reset held %0d cycles, released at %0t", cycles, $time);
   endtask

   initial begin
      bit seen_low;
      int ml;
      int il;

      model_reset();
      do_reset(5);

      // Full cycle: state returns to A green after 18 ticks (edge 18000);
      // the registered lamps show it one clock later.
      seen_low = 1'b0;
      for (int i = 0; i < 20000; i++) begin
         step(1'b0);
         if (!Ga) seen_low = 1'b1;
         else if (seen_low) break;
      end
      check("ga_return_cycle", m_cyc, 32'd18001);
      $display("full cycle done, A green again after %0d cycles", m_cyc);

      // Maintenance mid A green, then release
      repeat (1500) step(1'b0);
      repeat (2000) step(1'b1);
      $display("maintenance held 2000 cycles, released at %0t", $time);
      repeat (8500) step(1'b0);

      // Reset pulse mid B green
      for (int i = 0; i < 20000; i++) begin
         step(1'b0);
         if (Gb) break;
      end
      check("wait_b_green", {31'd0, Gb}, 32'd1);
      repeat (700) step(1'b0);
      do_reset(3);
      repeat (100) step(1'b0);

      // Randomized maintenance requests and reset pulses
      for (int s = 0; s < 8; s++) begin
         ml = ($urandom_range(0, 3) == 0) ? 1 : int'($urandom_range(2, 1500));
         il = $urandom_range(1, 3000);
         if ($urandom_range(0, 7) == 0) do_reset(int'($urandom_range(1, 4)));
         $display("segment %0d: MAINT for %0d cycles, then idle %0d cycles", s, ml, il);
         repeat (ml) step(1'b1);
         repeat (il) step(1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
